// File: rtl/cam_stream_gen.sv
// Camera video source: emits vsync/href/byte timing like a parallel RGB565 sensor,
// with four selectable test patterns and a completed-frame counter.
module cam_stream_gen #(
  parameter int H_ACTIVE    = 1280,
  parameter int H_TOTAL     = 1568,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_ACTIVE    = 480,
  parameter int V_FRONT     = 10
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic [7:0]  cam_data,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VSYNC  = 3'd1,
    VBACK  = 3'd2,
    ACTIVE = 3'd3,
    VFRONT = 3'd4
  } state_t;

  localparam logic [11:0] HC_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] HC_ACT  = 12'(H_ACTIVE);
  localparam logic [9:0]  VS_LAST = 10'(VSYNC_LINES - 1);
  localparam logic [9:0]  VB_LAST = 10'(V_BACK - 1);
  localparam logic [9:0]  VA_LAST = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  VF_LAST = 10'(V_FRONT - 1);

  state_t      state, state_n;
  logic [11:0] hc, hc_n;
  logic [9:0]  lc, lc_n;
  logic [9:0]  lines_last;
  logic [1:0]  pat_q, pat_n;
  logic [7:0]  bcnt, bcnt_n;
  logic        last_col, last_line;
  logic        vsync_n, href_n, done_n, busy_n;
  logic [7:0]  data_n;
  logic [15:0] pix;

  function automatic logic [15:0] bar_colour(input logic [2:0] sel);
    logic [15:0] c;
    case (sel)
      3'd0:    c = 16'hFFFF;
      3'd1:    c = 16'hFFE0;
      3'd2:    c = 16'h07FF;
      3'd3:    c = 16'h07E0;
      3'd4:    c = 16'hF81F;
      3'd5:    c = 16'hF800;
      3'd6:    c = 16'h001F;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

  function automatic logic [15:0] pixel_of(input logic [1:0] pat,
                                           input logic [9:0] x,
                                           input logic [7:0] y);
    logic [15:0] p;
    case (pat)
      2'd0:    p = {x[7:0], y};
      2'd1:    p = bar_colour(x[9:7]);
      2'd3:    p = (x[5] ^ y[5]) ? 16'hFFFF : 16'h0000;
      default: p = 16'h0000;
    endcase
    return p;
  endfunction

  function automatic logic [7:0] pick_byte(input logic [15:0] p, input logic odd);
    return odd ? p[7:0] : p[15:8];
  endfunction

  // Next-state and raster counters
  always_comb begin
    state_n    = state;
    hc_n       = hc;
    lc_n       = lc;
    pat_n      = pat_q;
    lines_last = VF_LAST;
    case (state)
      VSYNC:   lines_last = VS_LAST;
      VBACK:   lines_last = VB_LAST;
      ACTIVE:  lines_last = VA_LAST;
      default: lines_last = VF_LAST;
    endcase
    last_col  = (hc == HC_LAST);
    last_line = last_col && (lc == lines_last);

    if (state == IDLE) begin
      if (enable) begin
        state_n = VSYNC;
        hc_n    = '0;
        lc_n    = '0;
        pat_n   = pattern_sel;
      end
    end else begin
      hc_n = last_col ? 12'd0 : hc + 12'd1;
      lc_n = last_col ? lc + 10'd1 : lc;
      if (last_line) begin
        lc_n = '0;
        case (state)
          VSYNC:  state_n = VBACK;
          VBACK:  state_n = ACTIVE;
          ACTIVE: state_n = VFRONT;
          default: begin
            // Frame boundary: only here may enable stop the stream.
            if (enable) begin
              state_n = VSYNC;
              pat_n   = pattern_sel;
            end else begin
              state_n = IDLE;
            end
          end
        endcase
      end
    end
  end

  // Outputs are computed from next-cycle values so the registered copies line up with state
  always_comb begin
    vsync_n = (state_n == VSYNC);
    href_n  = (state_n == ACTIVE) && (hc_n < HC_ACT);
    busy_n  = (state_n != IDLE);
    done_n  = (state_n == VFRONT) && (hc_n == HC_LAST) && (lc_n == VF_LAST);
    pix     = pixel_of(pat_n, hc_n[10:1], lc_n[7:0]);
    data_n  = 8'h00;
    bcnt_n  = bcnt;
    if ((state_n == VSYNC) && (state != VSYNC)) begin
      bcnt_n = 8'h00;
    end else if (href_n) begin
      bcnt_n = bcnt + 8'd1;
    end
    if (href_n) begin
      data_n = (pat_n == 2'd2) ? bcnt : pick_byte(pix, hc_n[0]);
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state       <= IDLE;
      hc          <= '0;
      lc          <= '0;
      pat_q       <= '0;
      bcnt        <= '0;
      cam_vsync   <= 1'b0;
      cam_href    <= 1'b0;
      cam_data    <= 8'h00;
      frame_done  <= 1'b0;
      frame_count <= '0;
      busy        <= 1'b0;
    end else begin
      state      <= state_n;
      hc         <= hc_n;
      lc         <= lc_n;
      pat_q      <= pat_n;
      bcnt       <= bcnt_n;
      cam_vsync  <= vsync_n;
      cam_href   <= href_n;
      cam_data   <= data_n;
      frame_done <= done_n;
      busy       <= busy_n;
      if (done_n) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_cam_stream_gen.sv
// Randomized bench for cam_stream_gen against a frame-position reference model,
// plus directed checks for single/continuous frames, pattern latch, reset and wrap.
module tb_cam_stream_gen;

  localparam int HA = 8;
  localparam int HT = 12;
  localparam int VS = 1;
  localparam int VB = 1;
  localparam int VA = 2;
  localparam int VF = 1;
  localparam int FRAME = HT * (VS + VB + VA + VF);

  logic        pclk = 1'b0;
  logic        reset, enable;
  logic [1:0]  pattern_sel;
  logic        cam_vsync, cam_href, frame_done, busy;
  logic [7:0]  cam_data;
  logic [15:0] frame_count;

  cam_stream_gen #(
    .H_ACTIVE(HA), .H_TOTAL(HT), .VSYNC_LINES(VS),
    .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF)
  ) dut (
    .pclk(pclk), .reset(reset), .enable(enable), .pattern_sel(pattern_sel),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .frame_done(frame_done), .frame_count(frame_count), .busy(busy)
  );

  always #5 pclk = ~pclk;

  int n_vec = 0;
  int n_err = 0;
  int done_seen;

  // Reference model: running flag, position within the frame, latched pattern
  bit          m_run = 1'b0;
  int          m_p = 0;
  int          m_pat = 0;
  logic [7:0]  m_bc = 8'h00;
  logic [15:0] m_fc = 16'h0000;
  bit          e_vs, e_href, e_done;
  logic [7:0]  e_data;
  logic [7:0]  cap [FRAME];
  logic [7:0]  grad [8] = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h02, 8'h01, 8'h03, 8'h01};

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int bar_of(input int i);
    case (i)
      0: return 16'hFFFF;
      1: return 16'hFFE0;
      2: return 16'h07FF;
      3: return 16'h07E0;
      4: return 16'hF81F;
      5: return 16'hF800;
      6: return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_edge(input bit rst, input bit en, input logic [1:0] ps);
    int line, col, act, x, y, pix;
    if (rst) begin
      m_run = 0; m_p = 0; m_pat = 0; m_fc = 16'h0000; m_bc = 8'h00;
    end else if (!m_run) begin
      if (en) begin m_run = 1; m_p = 0; m_pat = int'(ps); m_bc = 8'h00; end
    end else if (m_p == FRAME - 1) begin
      if (en) begin m_p = 0; m_pat = int'(ps); m_bc = 8'h00; end
      else m_run = 0;
    end else begin
      m_p++;
    end
    e_vs = 0; e_href = 0; e_done = 0; e_data = 8'h00;
    if (m_run) begin
      line = m_p / HT;
      col  = m_p % HT;
      e_vs = (line < VS);
      act  = line - VS - VB;
      if (act >= 0 && act < VA && col < HA) begin
        e_href = 1;
        x = col / 2;
        y = act;
        case (m_pat)
          0:       pix = ((x % 256) * 256) + (y % 256);
          1:       pix = bar_of((x / 128) % 8);
          3:       pix = ((((x / 32) + (y / 32)) % 2) == 1) ? 16'hFFFF : 0;
          default: pix = 0;
        endcase
        if (m_pat == 2) e_data = m_bc;
        else            e_data = 8'((col % 2 == 0) ? (pix / 256) : (pix % 256));
        m_bc = m_bc + 8'd1;
      end
      if (m_p == FRAME - 1) begin
        e_done = 1;
        m_fc = m_fc + 16'd1;
      end
    end
  endtask

  task automatic step(input bit rst, input bit en, input logic [1:0] ps);
    reset = rst; enable = en; pattern_sel = ps;
    @(posedge pclk);
    model_edge(rst, en, ps);
    #1;
    check_val("vsync", 16'(cam_vsync), 16'(e_vs));
    check_val("href", 16'(cam_href), 16'(e_href));
    check_val("data", 16'(cam_data), 16'(e_data));
    check_val("frame_done", 16'(frame_done), 16'(e_done));
    check_val("frame_count", frame_count, m_fc);
    check_val("busy", 16'(busy), 16'(m_run));
    if (frame_done) done_seen++;
    if (m_run) cap[m_p] = cam_data;
  endtask

  initial begin
    bit en_r;
    int gap;
    reset = 1'b1; enable = 1'b0; pattern_sel = 2'd0;

    // Reset, then idle with enable low
    repeat (3) step(1, 0, 0);
    repeat (5) step(0, 0, 0);

    // Single frame, gradient, one-cycle enable
    done_seen = 0;
    step(0, 1, 0);
    repeat (70) step(0, 0, 0);
    check_val("single_done_pulses", 16'(done_seen), 16'd1);
    check_val("single_count", frame_count, 16'd1);
    check_val("single_busy", 16'(busy), 16'd0);
    for (int i = 0; i < 8; i++) check_val("grad_line1", 16'(cap[36 + i]), 16'(grad[i]));
    check_val("grad_blank", 16'(cap[44]), 16'h0000);

    // Continuous three frames, byte counter pattern
    step(1, 0, 0);
    gap = 0;
    for (int c = 0; c < 179; c++) begin
      step(0, 1, 2);
      if (!busy) gap++;
      if (m_p == 24) check_val("bytes_first", 16'(cam_data), 16'h0000);
      if (m_p == 43) check_val("bytes_last", 16'(cam_data), 16'h000F);
    end
    repeat (10) step(0, 0, 2);
    check_val("cont_gap", 16'(gap), 16'd0);
    check_val("cont_count", frame_count, 16'd3);

    // Pattern latch: switch 0 -> 3 mid-frame
    step(1, 0, 0);
    step(0, 1, 0);
    repeat (29) step(0, 1, 0);
    repeat (30) step(0, 1, 3);
    check_val("latch_cur_gradient", 16'(cap[37]), 16'h0001);
    repeat (29) step(0, 1, 3);
    repeat (40) step(0, 0, 3);
    check_val("latch_next_checker", 16'(cap[37]), 16'h0000);

    // Mid-frame reset at cycle 30
    step(1, 0, 0);
    step(0, 1, 1);
    repeat (28) step(0, 1, 1);
    step(1, 1, 1);
    check_val("rst_busy", 16'(busy), 16'd0);
    check_val("rst_data", 16'(cam_data), 16'h0000);
    step(0, 1, 1);
    check_val("restart_vsync", 16'(cam_vsync), 16'd1);
    repeat (59) step(0, 1, 1);
    repeat (10) step(0, 0, 1);

    // frame_count wrap from 0xFFFF
    step(1, 0, 0);
    step(0, 1, 0);
    repeat (10) step(0, 0, 0);
    force dut.frame_count = 16'hFFFF;
    #1;
    release dut.frame_count;
    m_fc = 16'hFFFF;
    done_seen = 0;
    repeat (60) step(0, 0, 0);
    check_val("wrap_count", frame_count, 16'h0000);
    check_val("wrap_done", 16'(done_seen), 16'd1);

    // Randomized run
    step(1, 0, 0);
    en_r = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 19) == 0) en_r = ~en_r;
      step(($urandom_range(0, 399) == 0), en_r, 2'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
